// File: rtl/meta_arbiter_rr_if.sv
// Valid/ready metadata channel shared by requesters and the arbitrated output.
// The m side drives valid/data; the s side drives ready.
interface metaIntf #(
    parameter int DATA_BITS = 32
);
    logic                 valid;
    logic                 ready;
    logic [DATA_BITS-1:0] data;

    modport m (
        output valid,
        output data,
        input  ready
    );

    modport s (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/meta_arbiter_rr.sv
// Round-robin arbiter merging N_SRC meta channels into one.
// Output goes through a 2-entry buffer that tags each beat with its source id.
module meta_arbiter_rr #(
    parameter int N_SRC     = 4,
    parameter int DATA_BITS = 32,
    parameter int ID_BITS   = $clog2(N_SRC)
) (
    input  logic               aclk,
    input  logic               aresetn,
    metaIntf.s                 s_meta [N_SRC],
    metaIntf.m                 m_meta,
    output logic [ID_BITS-1:0] m_id
);

    localparam int IW  = $clog2(N_SRC);
    localparam int IW1 = IW + 1;

    logic [N_SRC-1:0]     src_valid;
    logic [N_SRC-1:0]     src_ready;
    logic [DATA_BITS-1:0] src_data [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign src_valid[g]    = s_meta[g].valid;
        assign src_data[g]     = s_meta[g].data;
        assign s_meta[g].ready = src_ready[g];
    end

    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           count_q, count_d;
    logic [DATA_BITS-1:0] buf_data_q [2];
    logic [DATA_BITS-1:0] buf_data_d [2];
    logic [ID_BITS-1:0]   buf_id_q [2];
    logic [ID_BITS-1:0]   buf_id_d [2];

    logic          space;
    logic          grant_valid;
    logic [IW-1:0] grant;
    logic          accept;
    logic          dequeue;
    logic          out_valid;

    // Space depends only on registered state, keeping m_meta.ready off the input path.
    assign space     = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);

    always_comb begin
        logic [IW1-1:0] sum;
        logic [IW-1:0]  idx;
        grant_valid = 1'b0;
        grant       = '0;
        sum         = '0;
        idx         = '0;
        for (int k = 0; k < N_SRC; k++) begin
            sum = {1'b0, rr_ptr_q} + IW1'(k);
            if (sum >= IW1'(N_SRC)) begin
                sum = sum - IW1'(N_SRC);
            end
            idx = sum[IW-1:0];
            if (!grant_valid && src_valid[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

    // Gating with aresetn holds every ready low while reset is applied.
    assign accept  = aresetn && space && grant_valid;
    assign dequeue = out_valid && m_meta.ready;

    always_comb begin
        src_ready = '0;
        for (int i = 0; i < N_SRC; i++) begin
            src_ready[i] = accept && (grant == IW'(i));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q ^ accept;
        rd_ptr_d = rd_ptr_q ^ dequeue;
        count_d  = count_q;
        if (accept) begin
            rr_ptr_d = (grant == IW'(N_SRC - 1)) ? '0 : grant + 1'b1;
        end
        unique case ({accept, dequeue})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        buf_data_d = buf_data_q;
        buf_id_d   = buf_id_q;
        if (accept) begin
            buf_data_d[wr_ptr_q] = src_data[grant];
            buf_id_d[wr_ptr_q]   = ID_BITS'(grant);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; count gates its visibility.
    always_ff @(posedge aclk) begin
        buf_data_q <= buf_data_d;
        buf_id_q   <= buf_id_d;
    end

    assign m_meta.valid = out_valid;
    assign m_meta.data  = buf_data_q[rd_ptr_q];
    assign m_id         = buf_id_q[rd_ptr_q];

endmodule

// File: doc/meta_arbiter_rr.md
# meta_arbiter_rr

Round-robin arbiter that shares one metaIntf channel between `N_SRC` requesters. Each accepted beat is written into an internal 2-entry output buffer, tagged with the index of the source that sent it. The buffer gives a registered output with full throughput (one beat per cycle). The block sits in front of a shared meta consumer, such as a request queue or a meta register slice feeding a DMA/TLB engine, so that several user or host channels can issue over one path fairly.

## Interface
Parameters:
- `N_SRC`, default 4: number of requesters. Legal range is 2..16.
- `DATA_BITS`, default 32: payload width of every metaIntf port.
- `ID_BITS`, default `$clog2(N_SRC)`: width of the source tag.

Ports:
- `aclk`  in  1  clock. All logic is on the rising edge.
- `aresetn`  in  1  reset: one clock; reset is asynchronous and active-low.
- `s_meta[N_SRC]`  metaIntf.s  `DATA_BITS`  requester channels (valid/ready/data).
- `m_meta`  metaIntf.m  `DATA_BITS`  arbitrated output channel.
- `m_id`  out  `ID_BITS`  source index of the beat currently on `m_meta`. Valid only while `m_meta.valid` is 1.

## Operation
- **State:**
  - `rr_ptr[ID_BITS]`: highest-priority index.
  - Buffer of 2 entries, each holding {data, id}.
  - `wr_ptr`, `rd_ptr`: 1 bit each.
  - `count[1:0]`: values 0..2.
- **Space:** `space = (count != 2)`.
- **Grant:**
  - The grant goes to the first `i` with `s_meta[i].valid`, scanning cyclically `rr_ptr, rr_ptr+1, …, N_SRC-1, 0, …, rr_ptr-1`.
  - The scan is combinational and uses modulo `N_SRC` (not modulo `2^ID_BITS`).
- **Ready:**
  - `s_meta[i].ready = space && grant_valid && (grant == i)`.
  - At most one ready is high in any cycle.
  - Ready may depend on valid; valid must never depend on ready.
- **Accept:** an accept happens when `s_meta[grant].valid && s_meta[grant].ready`. On an accept:
  - Write {data, grant} into `buf[wr_ptr]`.
  - `wr_ptr` toggles.
  - `rr_ptr <= (grant == N_SRC-1) ? 0 : grant+1`.
- **No accept:** `rr_ptr` holds. It does not advance on idle cycles.
- **Output:**
  - `m_meta.valid = (count != 0)`.
  - `m_meta.data = buf[rd_ptr].data`.
  - `m_id = buf[rd_ptr].id`.
- **Dequeue:** when `m_meta.valid && m_meta.ready`, `rd_ptr` toggles.
- **Count update:** `count <= count + accept - dequeue`.
  - Accept and dequeue in the same cycle leave `count` unchanged.
  - Accept with count=2 cannot occur, because ready is low.
- **Fairness:** a requester that holds valid waits at most `N_SRC-1` accepted beats from other sources before it is granted, provided the output keeps draining.
- **Reset values** (asynchronous, applied while `aresetn` is 0):
  - `rr_ptr=0`, `count=0`, `wr_ptr=rd_ptr=0`.
  - `m_meta.valid=0`, every `s_meta[i].ready=0`.
  - Buffer data is not reset (don't-care).
- **Reset mid-operation:** buffered beats are discarded and the outputs drop within the same cycle. After release, the first beat is arbitrated from index 0.

## Timing
- **Latency:** a beat accepted at edge t is presented on `m_meta` starting in cycle t+1. This is 1 cycle from input handshake to output valid.
- **Throughput:**
  - With `m_meta.ready` held at 1, one beat is accepted and one emitted per cycle.
  - `count` stays at 1 in this steady state.
- **Backpressure:**
  - With `m_meta.ready=0`, two beats are absorbed (count reaches 2), then every ready goes low.
  - When `m_meta.ready` rises with count=2, that cycle dequeues only. Accepts resume in the next cycle.
- **Output stability:** while `m_meta.valid=1` and `m_meta.ready=0`, `m_meta.data` and `m_id` stay stable.
- **Ready path:** there is no combinational path from `m_meta.ready` to any `s_meta[i].ready`. Space is computed from registered `count` only.
- **Single requester:** one requester with continuous valid is served every cycle. `rr_ptr` then follows that requester's index + 1.

## Test plan
- **Reset:** assert `aresetn=0` while sources 0–3 are valid. Required: every ready is 0 and `m_meta.valid=0`. After release, the first grant goes to source 0, and `m_id=0` appears 1 cycle after the accept.
- **Round-robin:** `N_SRC=4`, all sources continuously valid with data = 0xA0+i, `m_meta.ready=1`. Required: output sequence of ids 0,1,2,3,0,1,… with data 0xA0,0xA1,0xA2,0xA3,…, and exactly one beat per cycle after the first.
- **Skip idle:** only sources 1 and 3 valid. Required: grants alternate 1,3,1,3 with no bubble cycles. Then with only source 2 valid, it is granted on the next accept.
- **Backpressure:** `m_meta.ready=0` for 5 cycles while all sources are valid. Required: exactly 2 accepts (ids 0,1), then all readies are 0. Data and id hold stable. After ready rises, the outputs drain in order 0,1, then source 2 is granted.
- **Wrap:** `N_SRC=3` (non-power-of-two), all sources valid. Required: ids 0,1,2,0. The value 3 never appears on `m_id`.
- **Mid-stream reset:** pulse `aresetn` low for 1 cycle with count=2. Required: `m_meta.valid` goes low immediately and the buffered beats are never emitted. Arbitration restarts at source 0.
